// File: rtl/tcb_mem_sub.sv
// TCB subordinate: byte-addressable memory answering every transfer exactly DLY cycles after its handshake.
// Optional backpressure (parameter BPR) is enabled by defining TCB_MEM_SUB_BPR_EN.
module tcb_mem_sub #(
  parameter int unsigned DLY  = 1,
  parameter int unsigned ADR  = 32,
  parameter int unsigned DAT  = 32,
  parameter int unsigned SIZE = 1024
`ifdef TCB_MEM_SUB_BPR_EN
  , parameter int unsigned BPR = 1
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  tcb_vld,
  output logic                                  tcb_rdy,
  input  logic                                  tcb_wen,
  input  logic                                  tcb_ren,
  input  logic [ADR-1:0]                        tcb_adr,
  input  logic [((($clog2($clog2(DAT/8)+1)) > 0) ? $clog2($clog2(DAT/8)+1) : 1)-1:0] tcb_siz,
  input  logic [DAT/8-1:0]                      tcb_ben,
  input  logic [DAT-1:0]                        tcb_wdt,
  output logic [DAT-1:0]                        tcb_rdt,
  output logic [1:0]                            tcb_sts
);

  localparam int unsigned BEN   = DAT / 8;
  localparam int unsigned SZC   = $clog2($clog2(BEN) + 1);
  localparam int unsigned SZW   = (SZC > 0) ? SZC : 1;
  localparam int unsigned WB    = $clog2(BEN);
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned IW    = (AW > WB) ? AW - WB : 1;
  localparam int unsigned DEPTH = SIZE / BEN;

  logic [DAT-1:0] mem [DEPTH];

  function automatic logic [DAT-1:0] lane_mask(input logic [BEN-1:0] ben);
    logic [DAT-1:0] m;
    m = '0;
    for (int i = 0; i < BEN; i++) m[8*i +: 8] = {8{ben[i]}};
    return m;
  endfunction

  function automatic logic misaligned(input logic [ADR-1:0] adr, input logic [SZW-1:0] siz);
    logic [ADR-1:0] mask;
    mask = (ADR'(1) << siz) - ADR'(1);
    return |(adr & mask);
  endfunction

  // Backpressure: rdy drops for BPR cycles after every accepted transfer.
`ifdef TCB_MEM_SUB_BPR_EN
  localparam int unsigned CW0 = $clog2(BPR + 1);
  localparam int unsigned CW  = (CW0 > 0) ? CW0 : 1;

  logic [CW-1:0] bpr_cnt;
  logic          rdy_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      bpr_cnt <= '0;
      rdy_r   <= 1'b1;
    end else if (tcb_vld && rdy_r && (BPR != 0)) begin
      bpr_cnt <= CW'(BPR);
      rdy_r   <= 1'b0;
    end else if (bpr_cnt != '0) begin
      bpr_cnt <= bpr_cnt - CW'(1);
      rdy_r   <= (bpr_cnt == CW'(1));
    end
  end

  assign tcb_rdy = rdy_r;
`else
  assign tcb_rdy = 1'b1;
`endif

  logic          trn;
  logic          mis;
  logic          oor;
  logic          err;
  logic [IW-1:0] idx;

  // Requests during reset are dropped entirely: no write, no response.
  assign trn = tcb_vld & tcb_rdy & ~rst;
  assign mis = misaligned(tcb_adr, tcb_siz);
  assign oor = |(tcb_adr >> AW);
  assign err = mis | oor;
  assign idx = IW'(tcb_adr >> WB);

  // Stage p0: response formed from the current request; the array is read
  // before the write at this edge lands, giving read-before-write.
  logic           vld_p0;
  logic [DAT-1:0] rdt_p0;
  logic [1:0]     sts_p0;

  always_comb begin
    vld_p0 = trn;
    rdt_p0 = '0;
    sts_p0 = '0;
    if (trn && (tcb_wen || tcb_ren)) sts_p0 = {oor, mis};
    if (trn && tcb_ren && !err)      rdt_p0 = mem[idx] & lane_mask(tcb_ben);
  end

  always_ff @(posedge clk) begin
    if (trn && tcb_wen && !err) begin
      for (int i = 0; i < BEN; i++) begin
        if (tcb_ben[i]) mem[idx][8*i +: 8] <= tcb_wdt[8*i +: 8];
      end
    end
  end

  // Stages p1..pDLY: only the valid bits are reset; data is gated by valid.
  generate
    if (DLY == 0) begin : g_comb
      assign tcb_rdt = rdt_p0;
      assign tcb_sts = sts_p0;
    end else begin : g_pipe
      logic           vld_pn [1:DLY];
      logic [DAT-1:0] rdt_pn [1:DLY];
      logic [1:0]     sts_pn [1:DLY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 1; k <= DLY; k++) vld_pn[k] <= 1'b0;
        end else begin
          vld_pn[1] <= vld_p0;
          for (int k = 2; k <= DLY; k++) vld_pn[k] <= vld_pn[k-1];
        end
      end

      always_ff @(posedge clk) begin
        rdt_pn[1] <= rdt_p0;
        sts_pn[1] <= sts_p0;
        for (int k = 2; k <= DLY; k++) begin
          rdt_pn[k] <= rdt_pn[k-1];
          sts_pn[k] <= sts_pn[k-1];
        end
      end

      assign tcb_rdt = vld_pn[DLY] ? rdt_pn[DLY] : '0;
      assign tcb_sts = vld_pn[DLY] ? sts_pn[DLY] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_tcb_mem_sub.sv
// Directed bench for tcb_mem_sub: a DLY=1 and a DLY=2 instance, plus a
// backpressure instance when TCB_MEM_SUB_BPR_EN is defined.
module tb_tcb_mem_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_vld = 1'b0, a_rdy, a_wen = 1'b0, a_ren = 1'b0;
  logic [31:0] a_adr = '0, a_wdt = '0, a_rdt;
  logic [1:0]  a_siz = '0, a_sts;
  logic [3:0]  a_ben = '0;

  logic        b_vld = 1'b0, b_rdy, b_wen = 1'b0, b_ren = 1'b0;
  logic [31:0] b_adr = '0, b_wdt = '0, b_rdt;
  logic [1:0]  b_siz = '0, b_sts;
  logic [3:0]  b_ben = '0;

  tcb_mem_sub #(.DLY(1), .ADR(32), .DAT(32), .SIZE(1024)
`ifdef TCB_MEM_SUB_BPR_EN
    , .BPR(0)
`endif
  ) u_d1 (
    .clk(clk), .rst(rst), .tcb_vld(a_vld), .tcb_rdy(a_rdy), .tcb_wen(a_wen),
    .tcb_ren(a_ren), .tcb_adr(a_adr), .tcb_siz(a_siz), .tcb_ben(a_ben),
    .tcb_wdt(a_wdt), .tcb_rdt(a_rdt), .tcb_sts(a_sts)
  );

  tcb_mem_sub #(.DLY(2), .ADR(32), .DAT(32), .SIZE(1024)
`ifdef TCB_MEM_SUB_BPR_EN
    , .BPR(0)
`endif
  ) u_d2 (
    .clk(clk), .rst(rst), .tcb_vld(b_vld), .tcb_rdy(b_rdy), .tcb_wen(b_wen),
    .tcb_ren(b_ren), .tcb_adr(b_adr), .tcb_siz(b_siz), .tcb_ben(b_ben),
    .tcb_wdt(b_wdt), .tcb_rdt(b_rdt), .tcb_sts(b_sts)
  );

`ifdef TCB_MEM_SUB_BPR_EN
  logic        c_vld = 1'b0, c_rdy;
  logic [31:0] c_rdt;
  logic [1:0]  c_sts;

  tcb_mem_sub #(.DLY(1), .ADR(32), .DAT(32), .SIZE(1024), .BPR(2)) u_d3 (
    .clk(clk), .rst(rst), .tcb_vld(c_vld), .tcb_rdy(c_rdy), .tcb_wen(1'b0),
    .tcb_ren(1'b1), .tcb_adr(32'h400), .tcb_siz(2'd2), .tcb_ben(4'hF),
    .tcb_wdt(32'h0), .tcb_rdt(c_rdt), .tcb_sts(c_sts)
  );
`endif

  // One DLY=1 transfer; returns #1 after the handshake edge.
  task automatic a_xfer(input logic wen, input logic ren, input logic [31:0] adr,
                        input logic [1:0] siz, input logic [3:0] ben, input logic [31:0] wdt);
    a_vld = 1'b1; a_wen = wen; a_ren = ren; a_adr = adr; a_siz = siz; a_ben = ben; a_wdt = wdt;
    @(posedge clk); #1;
    a_vld = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
  endtask

  task automatic b_drive(input logic vld, input logic wen, input logic ren,
                         input logic [31:0] adr, input logic [31:0] wdt);
    b_vld = vld; b_wen = wen; b_ren = ren; b_adr = adr; b_siz = 2'd2; b_ben = 4'hF; b_wdt = wdt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b00) begin failures++; $display("FAIL reset_d1 rdt=%h sts=%b exp 0/00", a_rdt, a_sts); end
    checks++; if (b_rdt !== 32'h0 || b_sts !== 2'b00) begin failures++; $display("FAIL reset_d2 rdt=%h sts=%b exp 0/00", b_rdt, b_sts); end
    checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got %b%b exp 11", a_rdy, b_rdy); end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    a_xfer(1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h33221100);
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b00) begin failures++; $display("FAIL write_rsp rdt=%h sts=%b exp 0/00", a_rdt, a_sts); end
    a_xfer(1'b0, 1'b1, 32'h10, 2'd2, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h33221100 || a_sts !== 2'b00) begin failures++; $display("FAIL read_full rdt=%h sts=%b exp 33221100/00", a_rdt, a_sts); end
  endtask

  task automatic test_partial;
    a_xfer(1'b1, 1'b0, 32'h10, 2'd2, 4'b0100, 32'hAABBCCDD);
    a_xfer(1'b0, 1'b1, 32'h10, 2'd2, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h33BB1100) begin failures++; $display("FAIL partial_wr rdt=%h exp 33bb1100", a_rdt); end
    a_xfer(1'b0, 1'b1, 32'h10, 2'd2, 4'b0011, 32'h0);
    checks++; if (a_rdt !== 32'h00001100) begin failures++; $display("FAIL partial_rd rdt=%h exp 00001100", a_rdt); end
  endtask

  task automatic test_errors;
    a_xfer(1'b1, 1'b0, 32'h12, 2'd2, 4'hF, 32'hFFFFFFFF);
    checks++; if (a_sts !== 2'b01) begin failures++; $display("FAIL misalign_wr sts=%b exp 01", a_sts); end
    a_xfer(1'b0, 1'b1, 32'h10, 2'd2, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h33BB1100) begin failures++; $display("FAIL wr_suppressed rdt=%h exp 33bb1100", a_rdt); end
    a_xfer(1'b0, 1'b1, 32'h400, 2'd2, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b10) begin failures++; $display("FAIL oor_rd rdt=%h sts=%b exp 0/10", a_rdt, a_sts); end
    a_xfer(1'b0, 1'b1, 32'h11, 2'd1, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b01) begin failures++; $display("FAIL misalign_rd rdt=%h sts=%b exp 0/01", a_rdt, a_sts); end
    a_xfer(1'b0, 1'b1, 32'h13, 2'd0, 4'b1000, 32'h0);
    checks++; if (a_rdt !== 32'h33000000 || a_sts !== 2'b00) begin failures++; $display("FAIL byte_rd rdt=%h sts=%b exp 33000000/00", a_rdt, a_sts); end
    @(posedge clk); #1;
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b00) begin failures++; $display("FAIL idle rdt=%h sts=%b exp 0/00", a_rdt, a_sts); end
  endtask

  task automatic test_rst_ignore;
    a_xfer(1'b1, 1'b0, 32'h20, 2'd2, 4'hF, 32'h12345678);
    rst = 1'b1;
    a_vld = 1'b1; a_wen = 1'b1; a_ren = 1'b1; a_adr = 32'h20; a_siz = 2'd2; a_ben = 4'hF; a_wdt = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if (a_rdt !== 32'h0 || a_sts !== 2'b00) begin failures++; $display("FAIL rst_no_rsp rdt=%h sts=%b exp 0/00", a_rdt, a_sts); end
    rst = 1'b0; a_vld = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
    a_xfer(1'b0, 1'b1, 32'h20, 2'd2, 4'hF, 32'h0);
    checks++; if (a_rdt !== 32'h12345678) begin failures++; $display("FAIL rst_no_wr rdt=%h exp 12345678", a_rdt); end
  endtask

  task automatic test_back_to_back;
    b_drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd1); @(posedge clk); #1;
    b_drive(1'b1, 1'b1, 1'b0, 32'h4, 32'd2); @(posedge clk); #1;
    b_drive(1'b1, 1'b1, 1'b0, 32'h8, 32'd3); @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 1'b1, 32'h0, 32'd0); @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 1'b1, 32'h4, 32'd0);
    checks++; if (b_rdt !== 32'h0) begin failures++; $display("FAIL d2_lat rdt=%h exp 0 one cycle after read", b_rdt); end
    @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd1) begin failures++; $display("FAIL d2_rd0 rdt=%h exp 1", b_rdt); end
    b_drive(1'b1, 1'b0, 1'b1, 32'h8, 32'd0); @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd2) begin failures++; $display("FAIL d2_rd1 rdt=%h exp 2", b_rdt); end
    b_drive(1'b1, 1'b1, 1'b1, 32'h0, 32'd9); @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd3) begin failures++; $display("FAIL d2_rd2 rdt=%h exp 3", b_rdt); end
    b_drive(1'b1, 1'b0, 1'b1, 32'h0, 32'd0); @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd1) begin failures++; $display("FAIL d2_rbw rdt=%h exp 1", b_rdt); end
    b_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'd0); @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd9) begin failures++; $display("FAIL d2_after_wr rdt=%h exp 9", b_rdt); end
    @(posedge clk); #1;
    checks++; if (b_rdt !== 32'h0 || b_sts !== 2'b00) begin failures++; $display("FAIL d2_drain rdt=%h sts=%b exp 0/00", b_rdt, b_sts); end
  endtask

  task automatic test_reset_inflight;
    b_drive(1'b1, 1'b0, 1'b1, 32'h4, 32'd0); @(posedge clk); #1;
    b_drive(1'b1, 1'b0, 1'b1, 32'h8, 32'd0); @(posedge clk); #1;
    checks++; if (b_rdt !== 32'd2) begin failures++; $display("FAIL inflight_pre rdt=%h exp 2", b_rdt); end
    b_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_rdt !== 32'h0 || b_sts !== 2'b00) begin failures++; $display("FAIL inflight_flush[%0d] rdt=%h sts=%b exp 0/00", i, b_rdt, b_sts); end
      @(posedge clk); #1;
    end
  endtask

`ifdef TCB_MEM_SUB_BPR_EN
  task automatic test_backpressure;
    logic [5:0] rdy_exp;
    rdy_exp = 6'b100100;
    c_vld = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (c_rdy !== rdy_exp[5-k]) begin failures++; $display("FAIL bpr_rdy[%0d] got %b exp %b", k, c_rdy, rdy_exp[5-k]); end
      checks++; if (c_sts !== ((k == 1 || k == 4) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL bpr_rsp[%0d] sts=%b", k, c_sts); end
      @(posedge clk); #1;
    end
    c_vld = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_write_read;
    test_partial;
    test_errors;
    test_rst_ignore;
    test_back_to_back;
    test_reset_inflight;
`ifdef TCB_MEM_SUB_BPR_EN
    test_backpressure;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
